// File: rtl/bounce_updater_n.sv
// Per-step physics/scoring engine for the colour-bounce game: hit test, move, recolour, score.
// Optional combo scoring is enabled by defining BOUNCE_COMBO_EN.
module bounce_updater_n #(
  parameter int          NUM_PLATS  = 4,
  parameter int          POS_W      = 7,
  parameter int          COLOR_W    = 3,
  parameter int          SCORE_W    = 32,
  parameter int          BOUNCE_LEN = 20,
  parameter int          HIT_WIN    = 4,
  parameter int          FLOOR_Y    = 116,
  parameter int          START_Y    = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         step,
  input  logic                         restart,
  input  logic [NUM_PLATS-1:0]         keys,
  input  logic [NUM_PLATS*POS_W-1:0]   plat_pos,
  output logic [POS_W-1:0]             ball_y,
  output logic [POS_W-1:0]             prev_ball_y,
  output logic [COLOR_W-1:0]           ball_color,
  output logic [NUM_PLATS*COLOR_W-1:0] plat_colors,
  output logic [SCORE_W-1:0]           score,
  output logic                         busy,
  output logic                         done,
  output logic                         gameover
);
  localparam int                           CNT_W     = $clog2(BOUNCE_LEN + 1);
  localparam logic [POS_W-1:0]             START_POS = POS_W'(START_Y);
  localparam logic [COLOR_W-1:0]           COL_ONE   = COLOR_W'(1);
  localparam logic [NUM_PLATS*COLOR_W-1:0] PLAT_INIT = {NUM_PLATS{COL_ONE}};

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_MOVE, S_DONE, S_OVER} state_t;

  state_t                       state_q, state_d;
  logic [POS_W-1:0]             ball_y_q, ball_y_d, prev_q, prev_d;
  logic [COLOR_W-1:0]           bc_q, bc_d, new_col, sel_col;
  logic [NUM_PLATS*COLOR_W-1:0] plat_q, plat_d;
  logic [SCORE_W-1:0]           score_q, score_d;
  logic [CNT_W-1:0]             up_q, up_d;
  logic                         hit_q, hit_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic [POS_W-1:0]             sel_pos;
  logic [POS_W:0]               win_hi;
  logic                         press, hit_now;
  logic [3:0]                   score_inc;
  int                           n_low, force_idx;
`ifdef BOUNCE_COMBO_EN
  logic [2:0]                   combo_q, combo_d;
  logic                         press_q, press_d;
`endif

  function automatic logic [COLOR_W-1:0] nz_color(input logic [COLOR_W-1:0] c);
    return (c == '0) ? COL_ONE : c;
  endfunction

  // Colour for platform j: LFSR rotated right by j*COLOR_W, low bits taken.
  function automatic logic [COLOR_W-1:0] rot_color(input logic [15:0] l, input int j);
    return nz_color(COLOR_W'({l, l} >> ((j * COLOR_W) % 16)));
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [3:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  // Hit test against the currently pressed key; window sum kept one bit wider so it cannot wrap.
  always_comb begin
    n_low   = 0;
    sel_pos = '0;
    sel_col = '0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      if (!keys[i]) begin
        n_low   = n_low + 1;
        sel_pos = plat_pos[i*POS_W +: POS_W];
        sel_col = plat_q[i*COLOR_W +: COLOR_W];
      end
    end
    press   = (n_low == 1);
    win_hi  = {1'b0, ball_y_q} + (POS_W+1)'(HIT_WIN);
    hit_now = press && (sel_col == bc_q) && (sel_pos >= ball_y_q) && ({1'b0, sel_pos} <= win_hi);
  end

  always_comb begin
    state_d   = state_q;
    ball_y_d  = ball_y_q;
    prev_d    = prev_q;
    bc_d      = bc_q;
    plat_d    = plat_q;
    score_d   = score_q;
    up_d      = up_q;
    hit_d     = hit_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    new_col   = nz_color(lfsr_q[COLOR_W-1:0]);
    force_idx = int'(lfsr_q[15:8]) % NUM_PLATS;
    score_inc = 4'd1;
`ifdef BOUNCE_COMBO_EN
    combo_d   = combo_q;
    press_d   = press_q;
`endif
    case (state_q)
      S_IDLE: if (step) state_d = S_EVAL;
      S_EVAL: begin
        hit_d   = hit_now;
`ifdef BOUNCE_COMBO_EN
        press_d = press;
`endif
        state_d = S_MOVE;
      end
      S_MOVE: begin
        prev_d = ball_y_q;
        if (hit_q)            up_d = CNT_W'(BOUNCE_LEN);
        else if (up_q != '0)  up_d = up_q - 1'b1;
        // Direction follows the pre-update counter; a hit always bounces up.
        if (hit_q || up_q != '0) ball_y_d = (ball_y_q == '0) ? '0 : ball_y_q - 1'b1;
        else                     ball_y_d = (&ball_y_q) ? ball_y_q : ball_y_q + 1'b1;
`ifdef BOUNCE_COMBO_EN
        if (hit_q) begin
          combo_d   = (combo_q == 3'd7) ? 3'd7 : combo_q + 3'd1;
          score_inc = {1'b0, combo_d};
        end else if (press_q || up_q == CNT_W'(1)) begin
          combo_d   = '0;
        end
`endif
        if (hit_q) begin
          bc_d = new_col;
          for (int j = 0; j < NUM_PLATS; j++)
            plat_d[j*COLOR_W +: COLOR_W] = (j == force_idx) ? new_col : rot_color(lfsr_q, j);
          score_d = sat_add(score_q, score_inc);
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = (int'(ball_y_q) >= FLOOR_Y) ? S_OVER : S_IDLE;
      S_OVER: begin
        if (restart) begin
          ball_y_d = START_POS;
          prev_d   = START_POS;
          bc_d     = COL_ONE;
          plat_d   = PLAT_INIT;
          score_d  = '0;
          up_d     = '0;
          hit_d    = 1'b0;
`ifdef BOUNCE_COMBO_EN
          combo_d  = '0;
          press_d  = 1'b0;
`endif
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ball_y_q <= START_POS;
      prev_q   <= START_POS;
      bc_q     <= COL_ONE;
      plat_q   <= PLAT_INIT;
      score_q  <= '0;
      up_q     <= '0;
      hit_q    <= 1'b0;
      lfsr_q   <= LFSR_SEED;
`ifdef BOUNCE_COMBO_EN
      combo_q  <= '0;
      press_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ball_y_q <= ball_y_d;
      prev_q   <= prev_d;
      bc_q     <= bc_d;
      plat_q   <= plat_d;
      score_q  <= score_d;
      up_q     <= up_d;
      hit_q    <= hit_d;
      lfsr_q   <= lfsr_d;
`ifdef BOUNCE_COMBO_EN
      combo_q  <= combo_d;
      press_q  <= press_d;
`endif
    end
  end

  assign ball_y      = ball_y_q;
  assign prev_ball_y = prev_q;
  assign ball_color  = bc_q;
  assign plat_colors = plat_q;
  assign score       = score_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign gameover    = (state_q == S_OVER);
endmodule

// File: doc/bounce_updater_n.md
Name: bounce_updater_n

Overview:
- Parameterised per-step physics/scoring engine for the colour-bounce game; successor to the fixed 4-platform updater.
- Owns ball position, ball/platform colours, bounce counter, score and game-over as internal state.
- Each `step` pulse from the game controller runs one update: hit test, move, recolour, score. It then returns a one-cycle `done`.
- Platform x-positions come from the platform scroller. Outputs feed the VGA drawer.

Parameters:
- NUM_PLATS, 4, number of platforms/keys
- POS_W, 7, width of ball and platform positions
- COLOR_W, 3, colour width; colour 0 reserved (background)
- SCORE_W, 32, score width
- BOUNCE_LEN, 20, upward steps after a hit
- HIT_WIN, 4, hit window: `ball_y <= plat_pos[i] <= ball_y + HIT_WIN`
- FLOOR_Y, 116, `ball_y >= FLOOR_Y` ends the game
- START_Y, 10, ball position after reset/restart
- LFSR_SEED, 16'hACE1, non-zero seed of the 16-bit colour LFSR

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- step  in  1  one-cycle update request; honoured only in IDLE
- restart  in  1  leaves OVER; honoured only in OVER
- keys  in  NUM_PLATS  active-low platform keys, bit i = platform i
- plat_pos  in  NUM_PLATS*POS_W  platform i at `[i*POS_W +: POS_W]`
- ball_y  out  POS_W  current ball position
- prev_ball_y  out  POS_W  ball position before the last update (for erase)
- ball_color  out  COLOR_W  ball colour
- plat_colors  out  NUM_PLATS*COLOR_W  platform i at `[i*COLOR_W +: COLOR_W]`
- score  out  SCORE_W  current score
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at the end of each update
- gameover  out  1  high in OVER

Behaviour:
- Reset (`resetn` = 0 at a clk edge) values:
  - `ball_y` = `prev_ball_y` = START_Y
  - `ball_color` = 1
  - all `plat_colors` = 1
  - score = 0, up_cnt = 0
  - `busy`/`done`/`gameover` = 0
  - LFSR = LFSR_SEED, state IDLE
- Reset overrides everything, including an update in progress.
- FSM states: IDLE -> EVAL -> MOVE -> DONE -> (IDLE | OVER).
  - IDLE: `step` = 1 -> EVAL; otherwise hold.
  - EVAL: register `hit` and key index.
    - Valid press: exactly one `keys` bit low. Zero or several low -> `hit` = 0.
    - `hit` = valid press AND `ball_color == plat_color[i]` AND `ball_y <= plat_pos[i] <= ball_y + HIT_WIN`.
    - The sum is computed at POS_W+1 bits (no wrap).
  - MOVE (all registers update together):
    - `prev_ball_y` <= `ball_y`.
    - Counter: if `hit`, up_cnt <= BOUNCE_LEN. Else if up_cnt > 0, up_cnt <= up_cnt-1.
    - Direction uses the up_cnt value before this update, except that a `hit` forces up.
    - Up: `ball_y` - 1, saturating at 0. Down: `ball_y` + 1, saturating at all-ones.
    - On `hit`:
      - New `ball_color` = LFSR[COLOR_W-1:0]; 0 is mapped to 1.
      - Each platform j takes LFSR bits rotated by j*COLOR_W, with 0 mapped to 1.
      - Platform `LFSR[15:8] % NUM_PLATS` is forced to the new ball colour, so at least one platform always matches.
      - Score +1, saturating at all-ones.
    - No `hit`: colours and score unchanged.
  - DONE: `done` = 1 for exactly one cycle. -> OVER if `ball_y >= FLOOR_Y`, else IDLE.
  - OVER: `gameover` = 1; `step` ignored.
    - `restart` = 1 -> reload all reset values except the LFSR, then IDLE.
- `busy` = 1 in EVAL, MOVE, DONE and OVER.
- LFSR: x^16+x^14+x^13+x^11, advances every clk and is never 0.
- Latency: `step` at edge T -> outputs updated at T+2 -> `done` high during cycle T+3 -> `busy` low at T+4 (IDLE).
- `step` while busy: dropped, no queuing.
- `keys` are sampled only in EVAL.

Optional Feature:
- Macro: BOUNCE_COMBO_EN.
- When defined:
  - 3-bit combo register, reset 0.
  - On `hit`, combo <= min(combo+1, 7) and score += new combo value.
  - A valid press with `hit` = 0, or the ball reaching a new down phase (up_cnt going 1 -> 0), clears combo.
  - Saturating score rules still apply.
- When undefined: no combo logic; each `hit` adds exactly 1.

Test Plan:
1. Reset, then 5 `step` pulses with `keys` = all 1 -> `ball_y` 10->15; `prev_ball_y` = 14; score 0; `done` at exactly T+3 each time.
2. `ball_y` = 20, `plat_pos[1]` = 22, colours equal, `keys` = 4'b1101, `step` -> `hit`; `ball_y` = 19; up_cnt = 20; score 1; ball colour != 0; at least one platform matches it.
3. Same setup, `keys` = 4'b1100 (two pressed), or `plat_pos[1]` = 25 (outside window) -> no hit; ball moves down; score unchanged.
4. Down steps from `ball_y` = 114 -> `gameover` after the step reaching 116. Further `step` ignored. `restart` -> `ball_y` = 10, score 0, IDLE.
5. `step` pulsed in EVAL/MOVE -> ignored (exactly one update). `resetn` = 0 during MOVE -> all reset values next cycle, no `done`.
6. BOUNCE_COMBO_EN: three consecutive hits -> score 1, 3, 6; a valid miss press -> combo 0 and next hit adds 1.
